// File: rtl/dat_tx_framer_pkg.sv
// Shared types and constants for the SD DAT-line transmit framer.
// No logic of its own; holds the FSM encoding, the CRC16 step and line constants.
// Not applicable: this file has no flow control.
package dat_tx_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // x^16 + x^12 + x^5 + 1, the CRC used on every SD DAT line
    localparam logic [15:0] CRC_POLY_DEFAULT = 16'h1021;

    // Lines idle high; the start bit pulls every line low
    localparam logic [3:0] IDLE_NIB  = 4'hF;
    localparam logic [3:0] START_NIB = 4'h0;

    // Index of the first CRC bit driven (MSB first)
    localparam logic [3:0] CRC_MSB_IDX = 4'd15;

    // One serial MSB-first CRC16 step: no reflection, no final XOR
    function automatic logic [15:0] crc16_step(input logic [15:0] cur,
                                               input logic        din,
                                               input logic [15:0] poly);
        logic fb;
        fb = cur[15] ^ din;
        return {cur[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/dat_tx_framer_if.sv
// Block-request and DAT-line bundle between a DAT serializer/host and the framer.
// Wiring only, zero latency.
// nib_valid/nib_ready handshake on the nibble stream; start is a bare pulse.
interface dat_tx_framer_if #(
    parameter int BS_WIDTH = 11
);
    logic                start;
    logic [BS_WIDTH-1:0] block_size;
    logic [3:0]          nib_in;
    logic                nib_valid;
    logic                nib_ready;
    logic [3:0]          dat_out;
    logic                dat_oe;
    logic                clk_en;
    logic                busy;
    logic                done;

    // Host / serializer side
    modport master (
        output start, block_size, nib_in, nib_valid,
        input  nib_ready, dat_out, dat_oe, clk_en, busy, done
    );

    // Framer side
    modport slave (
        input  start, block_size, nib_in, nib_valid,
        output nib_ready, dat_out, dat_oe, clk_en, busy, done
    );
endinterface

// File: rtl/dat_crc16_lane.sv
// Per-DAT-line CRC16: accumulates one data bit per enable, then shifts the CRC out MSB first.
// CRC register updates one cycle after enable/shift; crc[15] is the next bit to transmit.
// No backpressure; the owner gates enable and shift.
module dat_crc16_lane
    import dat_tx_framer_pkg::*;
#(
    parameter logic [15:0] CRC_POLY = CRC_POLY_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        shift,
    input  logic        din,
    output logic [15:0] crc
);

    // Clear wins over accumulate, accumulate over shift-out; the framer never asserts two at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc <= 16'h0000;
        end else if (clear) begin
            crc <= 16'h0000;
        end else if (enable) begin
            crc <= crc16_step(crc, din, CRC_POLY);
        end else if (shift) begin
            crc <= {crc[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/dat_tx_framer.sv
// Frames one data block onto four SD DAT lines: start bit, nibbles, per-line CRC16, stop bit.
// Start bit is driven on the edge that accepts start; each accepted nibble appears one edge later.
// Stalls (clk_en low, dat_out held) while nib_valid is low in DATA; CRC and stop phases never stall.
module dat_tx_framer
    import dat_tx_framer_pkg::*;
#(
    parameter int          BS_WIDTH = 11,
    parameter logic [15:0] CRC_POLY = CRC_POLY_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    dat_tx_framer_if.slave  bus
);

    state_t            state;
    logic [BS_WIDTH:0] total;
    logic [BS_WIDTH:0] count;
    logic [BS_WIDTH:0] count_nxt;
    logic [3:0]        bit_idx;

    logic              start_ok;
    logic              hs;
    logic              crc_shift;
    logic [15:0]       lane_crc [4];
    logic [3:0]        crc_msb;

    assign start_ok      = (state == ST_IDLE) && bus.start && (bus.block_size != '0);
    assign bus.nib_ready = (state == ST_DATA);
    assign hs            = bus.nib_valid && bus.nib_ready;
    assign crc_shift     = (state == ST_CRC);
    assign count_nxt     = count + 1'b1;
    assign bus.busy      = (state != ST_IDLE);

    // One CRC engine per DAT line; lane i sees bit i of every accepted nibble
    for (genvar i = 0; i < 4; i++) begin : g_lane
        dat_crc16_lane #(
            .CRC_POLY (CRC_POLY)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .clear  (start_ok),
            .enable (hs),
            .shift  (crc_shift),
            .din    (bus.nib_in[i]),
            .crc    (lane_crc[i])
        );
        assign crc_msb[i] = lane_crc[i][15];
    end

    // Frame sequencer with registered line outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            total       <= '0;
            count       <= '0;
            bit_idx     <= '0;
            bus.dat_out <= IDLE_NIB;
            bus.dat_oe  <= 1'b0;
            bus.clk_en  <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.dat_out <= IDLE_NIB;
                    bus.dat_oe  <= 1'b0;
                    bus.clk_en  <= 1'b0;
                    if (start_ok) begin
                        total       <= {bus.block_size, 1'b0};
                        count       <= '0;
                        bus.dat_out <= START_NIB;
                        bus.dat_oe  <= 1'b1;
                        bus.clk_en  <= 1'b1;
                        state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        bus.dat_out <= bus.nib_in;
                        bus.clk_en  <= 1'b1;
                        count       <= count_nxt;
                        if (count_nxt == total) begin
                            bit_idx <= CRC_MSB_IDX;
                            state   <= ST_CRC;
                        end
                    end else begin
                        // Card clock is gated, so holding the symbol loses nothing
                        bus.clk_en <= 1'b0;
                    end
                end
                ST_CRC: begin
                    bus.dat_out <= crc_msb;
                    bus.clk_en  <= 1'b1;
                    bit_idx     <= bit_idx - 4'd1;
                    if (bit_idx == 4'd0) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    bus.dat_out <= IDLE_NIB;
                    bus.clk_en  <= 1'b1;
                    bus.done    <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dat_tx_framer.sv
module tb_dat_tx_framer;

    localparam int BS_WIDTH = 11;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    dat_tx_framer_if #(.BS_WIDTH(BS_WIDTH)) bus ();

    dat_tx_framer #(
        .BS_WIDTH (BS_WIDTH),
        .CRC_POLY (16'h1021)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string tc       = "reset";

    logic [3:0] nibs [$];

    // Monitor: every clk_en symbol, done position, and stall-cycle behaviour
    logic [3:0] sym_q [$];
    int         done_total  = 0;
    int         done_pos    = -1;
    int         hold_cycles = 0;
    int         hold_bad    = 0;
    logic [3:0] last_sym    = 4'hF;

    always @(negedge clock) begin
        if (bus.busy && !bus.clk_en && !reset) begin
            hold_cycles++;
            if (bus.dat_out !== last_sym) hold_bad++;
        end
        if (bus.clk_en) begin
            sym_q.push_back(bus.dat_out);
            last_sym = bus.dat_out;
        end
        if (bus.done) begin
            done_total++;
            done_pos = sym_q.size();
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", tc, tag, got, exp);
        end
    endtask

    function automatic logic [3:0] get_sym(input int idx);
        if (idx >= 0 && idx < sym_q.size()) return sym_q[idx];
        return 4'hX;
    endfunction

    // Pulse start, then present nibbles until all 2*bs have been handed over
    task automatic start_and_feed(input int bs, input int stall_at, input int stall_len,
                                  input int restart_at, output int base, output int hold0);
        int i;
        int stalled;
        int n;
        bit restarted;
        base      = sym_q.size();
        hold0     = hold_cycles;
        i         = 0;
        stalled   = 0;
        n         = 0;
        restarted = 1'b0;
        @(negedge clock);
        bus.start      = 1'b1;
        bus.block_size = bs[BS_WIDTH-1:0];
        @(negedge clock);
        bus.start = 1'b0;
        while (i < 2 * bs && n < 20000) begin
            bus.start = 1'b0;
            if (i == restart_at && !restarted) begin
                bus.start      = 1'b1;
                bus.block_size = 11'd5;
                restarted      = 1'b1;
            end
            if (i == stall_at && stalled < stall_len) begin
                bus.nib_valid = 1'b0;
                if (bus.nib_ready) stalled++;
            end else begin
                bus.nib_valid = 1'b1;
                bus.nib_in    = nibs[i];
                if (bus.nib_ready) i++;
            end
            @(negedge clock);
            n++;
        end
        bus.start     = 1'b0;
        bus.nib_valid = 1'b0;
        check_val("fed_all", i, 2 * bs);
    endtask

    // Wait (bounded) for done, then check the line returns to idle on the following edge
    task automatic finish_block();
        int n;
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_val("done_seen", bus.done, 1'b1);
        check_val("stop_busy", bus.busy, 1'b0);
        @(negedge clock);
        check_val("post_oe", bus.dat_oe, 1'b0);
        check_val("post_clk_en", bus.clk_en, 1'b0);
        check_val("post_done", bus.done, 1'b0);
        check_val("post_dat", bus.dat_out, 4'hF);
        #1;
    endtask

    // Compare captured symbols against the hand-derived frame
    task automatic check_frame(input int base, input int bs, input logic [15:0] e0,
                               input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        int          len;
        int          derr;
        logic [3:0]  s;
        logic [15:0] c0, c1, c2, c3;
        len  = 1 + 2 * bs + 16 + 1;
        derr = 0;
        c0 = '0; c1 = '0; c2 = '0; c3 = '0;
        check_val("len", sym_q.size() - base, len);
        check_val("start_bit", get_sym(base), 4'h0);
        for (int j = 0; j < 2 * bs; j++) begin
            if (get_sym(base + 1 + j) !== nibs[j]) derr++;
        end
        check_val("data_errs", derr, 0);
        for (int k = 0; k < 16; k++) begin
            s  = get_sym(base + 1 + 2 * bs + k);
            c0 = {c0[14:0], s[0]};
            c1 = {c1[14:0], s[1]};
            c2 = {c2[14:0], s[2]};
            c3 = {c3[14:0], s[3]};
        end
        check_val("crc_lane0", c0, e0);
        check_val("crc_lane1", c1, e1);
        check_val("crc_lane2", c2, e2);
        check_val("crc_lane3", c3, e3);
        check_val("stop_bit", get_sym(base + len - 1), 4'hF);
        check_val("done_pos", done_pos - base, len);
    endtask

    initial begin
        int          base;
        int          h0;
        int          d0;
        int          s0;
        int          n;
        logic [71:0] msg;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.block_size = '0;
        bus.nib_in     = 4'h0;
        bus.nib_valid  = 1'b0;

        @(negedge clock);
        check_val("dat_out", bus.dat_out, 4'hF);
        check_val("dat_oe", bus.dat_oe, 1'b0);
        check_val("clk_en", bus.clk_en, 1'b0);
        check_val("done", bus.done, 1'b0);
        check_val("busy", bus.busy, 1'b0);
        check_val("nib_ready", bus.nib_ready, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // bs=1, nibbles A,5: lanes 0/2 see bits 0,1 -> 0x1021; lanes 1/3 see 1,0 -> 0x2042
        tc = "bs1";
        nibs.delete(); nibs.push_back(4'hA); nibs.push_back(4'h5);
        start_and_feed(1, -1, 0, -1, base, h0);
        finish_block();
        check_frame(base, 1, 16'h1021, 16'h2042, 16'h1021, 16'h2042);
        check_val("no_gaps", hold_cycles - h0, 0);

        // Lane 0 carries "123456789" MSB first: CRC16/XMODEM check value
        tc = "ascii";
        msg = "123456789";
        nibs.delete();
        for (int j = 0; j < 72; j++) nibs.push_back({3'b000, msg[71 - j]});
        start_and_feed(36, -1, 0, -1, base, h0);
        finish_block();
        check_frame(base, 36, 16'h31C3, 16'h0000, 16'h0000, 16'h0000);

        // bs=4, all lanes bits 1,0,0,0,0,0,0,0 -> 0x9188 on every lane
        tc = "bs4_flow";
        nibs.delete(); nibs.push_back(4'hF);
        for (int j = 0; j < 7; j++) nibs.push_back(4'h0);
        start_and_feed(4, -1, 0, -1, base, h0);
        finish_block();
        check_frame(base, 4, 16'h9188, 16'h9188, 16'h9188, 16'h9188);
        check_val("no_gaps", hold_cycles - h0, 0);

        tc = "bs4_stall";
        start_and_feed(4, 2, 3, -1, base, h0);
        finish_block();
        check_frame(base, 4, 16'h9188, 16'h9188, 16'h9188, 16'h9188);
        check_val("stall_cycles", hold_cycles - h0, 3);
        check_val("stall_held", hold_bad, 0);

        // Zero-length start must be ignored
        tc = "bs_zero";
        s0 = sym_q.size();
        d0 = done_total;
        @(negedge clock);
        bus.start      = 1'b1;
        bus.block_size = '0;
        @(negedge clock);
        bus.start = 1'b0;
        check_val("busy", bus.busy, 1'b0);
        check_val("oe", bus.dat_oe, 1'b0);
        repeat (5) @(negedge clock);
        check_val("no_syms", sym_q.size() - s0, 0);
        check_val("no_done", done_total - d0, 0);

        // Start during DATA must not disturb the running block
        tc = "start_in_data";
        nibs.delete(); nibs.push_back(4'hA); nibs.push_back(4'h5);
        start_and_feed(1, -1, 0, 1, base, h0);
        finish_block();
        check_frame(base, 1, 16'h1021, 16'h2042, 16'h1021, 16'h2042);
        repeat (3) @(negedge clock);
        check_val("stays_idle", bus.busy, 1'b0);

        // Reset in the middle of the CRC phase
        tc = "rst_mid_crc";
        start_and_feed(1, -1, 0, -1, base, h0);
        n = 0;
        while (sym_q.size() < base + 8 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_val("in_crc", bus.busy, 1'b1);
        d0 = done_total;
        reset = 1'b1;
        #1;
        check_val("oe", bus.dat_oe, 1'b0);
        check_val("dat", bus.dat_out, 4'hF);
        check_val("clk_en", bus.clk_en, 1'b0);
        check_val("busy", bus.busy, 1'b0);
        s0 = sym_q.size();
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        check_val("no_done", done_total - d0, 0);
        check_val("no_syms", sym_q.size() - s0, 0);
        start_and_feed(1, -1, 0, -1, base, h0);
        finish_block();
        check_frame(base, 1, 16'h1021, 16'h2042, 16'h1021, 16'h2042);

        // Largest block, all zero: 4094 data nibbles, count must not wrap
        tc = "bs_max";
        nibs.delete();
        for (int j = 0; j < 4094; j++) nibs.push_back(4'h0);
        start_and_feed(2047, -1, 0, -1, base, h0);
        finish_block();
        check_frame(base, 2047, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dat_tx_framer.md
DAT_TX_FRAMER -- requirements
Module: dat_tx_framer

Interface
REQ-001 SHALL have parameter BS_WIDTH, default 11, width of block_size in bytes.
REQ-002 SHALL have parameter CRC_POLY, default 16'h1021, CRC16 polynomial (x^16+x^12+x^5+1).
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse that requests transmission of one block.
REQ-006 SHALL have port block_size  in  BS_WIDTH  block length in bytes, sampled on the accepted start.
REQ-007 SHALL have port nib_in  in  4  data nibble from the DAT serializer; bit i drives DAT line i.
REQ-008 SHALL have port nib_valid  in  1  nib_in holds valid data.
REQ-009 SHALL have port nib_ready  out  1  framer accepts nib_in at this edge.
REQ-010 SHALL have port dat_out  out  4  registered symbol for the four DAT lines.
REQ-011 SHALL have port dat_oe  out  1  registered line-driver enable.
REQ-012 SHALL have port clk_en  out  1  registered; high when dat_out carries a new symbol this cycle (card clock gate).
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse coincident with the stop-bit cycle.

Function
REQ-015 SHALL implement states IDLE, DATA, CRC, STOP.
REQ-016 In IDLE, a start with block_size != 0 SHALL, at that edge, latch total = 2*block_size nibbles, clear count and all four CRCs, set dat_out=4'h0 (start bit), dat_oe=1, clk_en=1, go to DATA.
REQ-017 In IDLE, a start with block_size == 0 SHALL be ignored (no dat_oe, no done).
REQ-018 A start outside IDLE SHALL be ignored.
REQ-019 nib_ready SHALL be 1 only in DATA (combinational from state); handshake = nib_valid & nib_ready.
REQ-020 In DATA, on handshake: dat_out<=nib_in, clk_en<=1, count+1, each lane CRC updated with its bit; on the handshake that makes count==total, go to CRC.
REQ-021 In DATA without handshake: dat_out holds, clk_en<=0, CRC and count hold (stall; no symbol lost or repeated on the card side).
REQ-022 Per-lane CRC SHALL be CRC16, init 0, no reflection, no final XOR, MSB-first serial update.
REQ-023 In CRC, each edge SHALL output dat_out[i]=crc_i bit k for k=15 down to 0 with clk_en=1; after bit 0, go to STOP (exactly 16 cycles, no stall).
REQ-024 In STOP, the edge SHALL output dat_out=4'hF, clk_en=1, done=1, and go to IDLE.
REQ-025 The edge leaving STOP SHALL set dat_oe=0, clk_en=0, done=0, dat_out=4'hF.
REQ-026 With nib_valid constantly 1, a block SHALL occupy exactly 1+2*block_size+16+1 consecutive clk_en cycles.
REQ-027 count SHALL be BS_WIDTH+1 bits wide; 2*max block_size SHALL not wrap.

Reset
REQ-028 reset SHALL immediately force state=IDLE, dat_out=4'hF, dat_oe=0, clk_en=0, done=0, count=0, CRCs=0, independent of clock.
REQ-029 reset mid-block SHALL abandon the block with no done pulse; the first start after release SHALL frame normally.

Structure
REQ-030 A shared package SHALL hold state encoding, CRC_POLY default, and the idle nibble 4'hF.
REQ-031 One sub-module dat_crc16_lane (1-bit in, enable, clear, 16-bit CRC, shift-out) SHALL be instantiated four times.

Verification
REQ-032 block_size=1, nib_valid=1, nibbles 4'hA,4'h5 -> clk_en symbols: 0,A,5, 16 CRC symbols, F; done in cycle 20; dat_oe low next cycle.
REQ-033 block_size=36, lane 0 carries ASCII "123456789" MSB-first, lanes 1-3 zero -> lane 0 CRC 16'h31C3, lanes 1-3 16'h0000.
REQ-034 block_size=4, nib_valid dropped for 3 cycles after nibble 2 -> clk_en low 3 cycles, dat_out held, total 26 clk_en cycles, CRC unchanged vs. unstalled run.
REQ-035 start with block_size=0, then start asserted during DATA of a valid block -> neither ignored start changes output or count.
REQ-036 reset asserted mid-CRC -> dat_oe=0, dat_out=4'hF same cycle, no done; next start produces a correct complete frame.
REQ-037 block_size=2047 all-zero data -> 4095+16+... symbols with CRCs 16'h0000, no count wrap.
